// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    // Bit-position counter width; at least one bit, even for tiny operands.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation: out = neg ? -in : in.
module cond_negate #(
    parameter int unsigned W = 4
) (
    input  logic         neg,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    assign out = neg ? (~in + W'(1)) : in;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, with optional
// two's-complement operands handled as sign-magnitude around an unsigned core.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   inp1,
    input  logic [WIDTH-1:0]   inp2,
    output logic [2*WIDTH-1:0] product,
    output logic               sinal,
    output logic               busy,
    output logic               done
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = cnt_w(WIDTH);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [PW-1:0]      acc;
    logic [PW-1:0]      mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg_flag;

    logic               neg1_c;
    logic               neg2_c;
    logic [WIDTH-1:0]   mag1_c;
    logic [WIDTH-1:0]   mag2_c;
    logic [PW-1:0]      result_c;

    assign neg1_c = signed_mode & inp1[WIDTH-1];
    assign neg2_c = signed_mode & inp2[WIDTH-1];

    cond_negate #(.W(WIDTH)) u_mag1 (
        .neg (neg1_c),
        .in  (inp1),
        .out (mag1_c)
    );

    cond_negate #(.W(WIDTH)) u_mag2 (
        .neg (neg2_c),
        .in  (inp2),
        .out (mag2_c)
    );

    cond_negate #(.W(PW)) u_result (
        .neg (neg_flag),
        .in  (acc),
        .out (result_c)
    );

    // Multiplicand shifts left as the multiplier shifts right, so the
    // addend at each step is the multiplicand weighted by the current bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            neg_flag <= 1'b0;
            product  <= '0;
            sinal    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand    <= PW'(mag1_c);
                        mplier   <= mag2_c;
                        neg_flag <= neg1_c ^ neg2_c;
                        count    <= '0;
                        acc      <= '0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    product <= result_c;
                    sinal   <= neg_flag & (acc != '0);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
